// File: rtl/fft_interleave_stream_pkg.sv
// Shared FFT stream package: default sample width, frame length and the
// FILL/DRAIN state encoding used by the interleaving stream stage.
package fft_interleave_stream_pkg;

    localparam int fft_data_width = 8;
    localparam int fft_no_in_out  = 32;

    typedef enum logic {
        st_fill  = 1'b0,
        st_drain = 1'b1
    } fft_state_t;

endpackage

// File: rtl/fft_interleave_stream_if.sv
// Stream bus for the interleaver: input side, output side and a state tap.
// Handshake: a sample moves when valid and ready are both 1 on a rising clk edge.
interface fft_interleave_stream_if
    import fft_interleave_stream_pkg::*;
    #(parameter int data_width = fft_data_width) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] in_data_real;
    logic [data_width-1:0] in_data_imag;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] out_data_real;
    logic [data_width-1:0] out_data_imag;
    logic                  out_last;
    fft_state_t            dbg_state;

    modport slave (
        input  in_valid, in_data_real, in_data_imag, out_ready,
        output in_ready, out_valid, out_data_real, out_data_imag, out_last, dbg_state
    );

    modport master (
        output in_valid, in_data_real, in_data_imag, out_ready,
        input  in_ready, out_valid, out_data_real, out_data_imag, out_last, dbg_state
    );

endinterface

// File: rtl/fft_interleave_idx.sv
// Read-address map: output position n fetches n/2 (even n) or N/2 + (n-1)/2 (odd n).
module fft_interleave_idx #(
    parameter int no_in_out = 32,
    parameter int cw        = $clog2(no_in_out)
) (
    input  logic [cw-1:0] rd_cnt,
    output logic [cw-1:0] buf_idx
);

    localparam logic [cw-1:0] half = cw'(no_in_out / 2);

    logic [cw-1:0] pair;

    always_comb begin
        pair = rd_cnt >> 1;
        if (rd_cnt[0]) begin
            buf_idx = half + pair;
        end else begin
            buf_idx = pair;
        end
    end

endmodule

// File: rtl/fft_interleave_stream.sv
// Frame interleaver: buffers N samples in natural order, then replays them
// with first and second halves interleaved (inverse of an even/odd split).
module fft_interleave_stream
    import fft_interleave_stream_pkg::*;
    #(
    parameter int data_width = fft_data_width,
    parameter int no_in_out  = fft_no_in_out
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fft_interleave_stream_if.slave bus
);

    localparam int              cw      = $clog2(no_in_out);
    localparam logic [cw-1:0]   cnt_max = cw'(no_in_out - 1);

    fft_state_t state_q, state_d;
    logic [cw-1:0] wr_cnt_q, rd_cnt_q, rd_idx;
    logic in_fire, out_fire;
    logic in_ready_c, out_valid_c, out_last_c;
    logic [2*data_width-1:0] buffer_q [no_in_out];

    // rst_n gates acceptance so nothing is taken while reset is held.
    assign in_fire  = bus.in_valid && rst_n && (state_q == st_fill);
    assign out_fire = bus.out_ready && (state_q == st_drain);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= st_fill;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                wr_cnt_q <= (wr_cnt_q == cnt_max) ? '0 : wr_cnt_q + cw'(1);
            end
            if (out_fire) begin
                rd_cnt_q <= (rd_cnt_q == cnt_max) ? '0 : rd_cnt_q + cw'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        unique case (state_q)
            st_fill: begin
                in_ready_c = rst_n;
                if (in_fire && (wr_cnt_q == cnt_max)) begin
                    state_d = st_drain;
                end
            end
            st_drain: begin
                out_valid_c = 1'b1;
                out_last_c  = (rd_cnt_q == cnt_max);
                if (out_fire && out_last_c) begin
                    state_d = st_fill;
                end
            end
            default: state_d = st_fill;
        endcase
    end

    // Sample storage carries no reset; contents are only read after a full fill.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buffer_q[wr_cnt_q] <= {bus.in_data_imag, bus.in_data_real};
        end
    end

    fft_interleave_idx #(
        .no_in_out (no_in_out),
        .cw        (cw)
    ) u_idx (
        .rd_cnt  (rd_cnt_q),
        .buf_idx (rd_idx)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_last  = out_last_c;
    assign bus.dbg_state = state_q;
    assign {bus.out_data_imag, bus.out_data_real} = buffer_q[rd_idx];

endmodule
